// File: rtl/mfcc_mel_pkg.sv
// rtl/mfcc_mel_pkg.sv - default dimensions and FSM state type for the mel filterbank accumulator
package mfcc_mel_pkg;

   localparam int DEF_NUM_BINS    = 257;
   localparam int DEF_NUM_FILTERS = 26;
   localparam int DEF_BIN_W       = 9;
   localparam int DEF_FILT_W      = 5;
   localparam int DEF_SPEC_W      = 32;
   localparam int DEF_WGT_W       = 8;
   localparam int DEF_ACC_W       = 48;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } mel_state_e;

endpackage

// File: rtl/mfcc_mel_filter_acc_if.sv
// rtl/mfcc_mel_filter_acc_if.sv - frame control, spectrum/weight read and energy output bundle
interface mfcc_mel_filter_acc_if
   import mfcc_mel_pkg::*;
#(
   parameter int BIN_W  = DEF_BIN_W,
   parameter int FILT_W = DEF_FILT_W,
   parameter int SPEC_W = DEF_SPEC_W,
   parameter int WGT_W  = DEF_WGT_W,
   parameter int ACC_W  = DEF_ACC_W
) ();

   logic              start;
   logic              busy;
   logic [BIN_W-1:0]  spec_addr;
   logic [SPEC_W-1:0] spec_rdata;
   logic [FILT_W-1:0] rom_sel;
   logic [BIN_W-1:0]  rom_addr;
   logic [WGT_W-1:0]  rom_data;
   logic              out_valid;
   logic [FILT_W-1:0] out_idx;
   logic [ACC_W-1:0]  out_energy;
   logic              done;

   // Environment side: frame control, spectrum RAM, weight ROM mux, energy sink
   modport master (
      output start, spec_rdata, rom_data,
      input  busy, spec_addr, rom_sel, rom_addr, out_valid, out_idx, out_energy, done
   );

   modport slave (
      input  start, spec_rdata, rom_data,
      output busy, spec_addr, rom_sel, rom_addr, out_valid, out_idx, out_energy, done
   );

endinterface

// File: rtl/mfcc_mel_mac.sv
// rtl/mfcc_mel_mac.sv - S2 multiply, S3 accumulate and registered energy output.
// Build option MEL_ACC_SAT_EN: accumulation saturates at all-ones instead of wrapping.
module mfcc_mel_mac
   import mfcc_mel_pkg::*;
#(
   parameter int NUM_FILTERS = DEF_NUM_FILTERS,
   parameter int FILT_W      = DEF_FILT_W,
   parameter int SPEC_W      = DEF_SPEC_W,
   parameter int WGT_W       = DEF_WGT_W,
   parameter int ACC_W       = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              first_i,
   input  logic              last_i,
   input  logic [FILT_W-1:0] filt_i,
   input  logic [WGT_W-1:0]  wgt_i,
   input  logic [SPEC_W-1:0] spec_i,
   output logic              out_valid_o,
   output logic [FILT_W-1:0] out_idx_o,
   output logic [ACC_W-1:0]  out_energy_o,
   output logic              done_o
);

   localparam int PROD_W = SPEC_W + WGT_W;
   localparam logic [FILT_W-1:0] LAST_FILT = FILT_W'(NUM_FILTERS - 1);

   logic [PROD_W-1:0] prod_d, prod_q;
   logic              s2_valid_q, s2_first_q, s2_last_q;
   logic [FILT_W-1:0] s2_filt_q;
   logic [ACC_W-1:0]  acc_d, acc_q;
   logic              s3_valid_q, s3_last_q;
   logic [FILT_W-1:0] s3_filt_q;
   logic              out_valid_q, done_q;
   logic [FILT_W-1:0] out_idx_q;
   logic [ACC_W-1:0]  out_energy_q;

`ifdef MEL_ACC_SAT_EN
   logic [ACC_W:0] sum;
`endif

   assign prod_d = PROD_W'(spec_i) * PROD_W'(wgt_i);

   always_comb begin
`ifdef MEL_ACC_SAT_EN
      sum = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
      if (s2_first_q)
         acc_d = ACC_W'(prod_q);
      else if (sum[ACC_W])
         acc_d = '1;
      else
         acc_d = sum[ACC_W-1:0];
`else
      acc_d = s2_first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q       <= '0;
         s2_valid_q   <= 1'b0;
         s2_first_q   <= 1'b0;
         s2_last_q    <= 1'b0;
         s2_filt_q    <= '0;
         acc_q        <= '0;
         s3_valid_q   <= 1'b0;
         s3_last_q    <= 1'b0;
         s3_filt_q    <= '0;
         out_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         out_idx_q    <= '0;
         out_energy_q <= '0;
      end else begin
         prod_q     <= prod_d;
         s2_valid_q <= valid_i;
         s2_first_q <= first_i;
         s2_last_q  <= last_i;
         s2_filt_q  <= filt_i;
         if (s2_valid_q)
            acc_q <= acc_d;
         s3_valid_q <= s2_valid_q;
         s3_last_q  <= s2_last_q;
         s3_filt_q  <= s2_filt_q;
         // Energy leaves through its own register so it is stable for a full filter period
         out_valid_q <= s3_valid_q & s3_last_q;
         done_q      <= s3_valid_q & s3_last_q & (s3_filt_q == LAST_FILT);
         if (s3_valid_q & s3_last_q) begin
            out_idx_q    <= s3_filt_q;
            out_energy_q <= acc_q;
         end
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_idx_o    = out_idx_q;
   assign out_energy_o = out_energy_q;
   assign done_o       = done_q;

endmodule

// File: rtl/mfcc_mel_filter_acc.sv
// rtl/mfcc_mel_filter_acc.sv - mel filterbank sequencer: frame FSM, bin/filter counters, S1 register.
// Build option MEL_ACC_SAT_EN selects saturating accumulation in mfcc_mel_mac.
module mfcc_mel_filter_acc
   import mfcc_mel_pkg::*;
#(
   parameter int NUM_BINS    = DEF_NUM_BINS,
   parameter int NUM_FILTERS = DEF_NUM_FILTERS,
   parameter int BIN_W       = DEF_BIN_W,
   parameter int FILT_W      = DEF_FILT_W,
   parameter int SPEC_W      = DEF_SPEC_W,
   parameter int WGT_W       = DEF_WGT_W,
   parameter int ACC_W       = DEF_ACC_W
) (
   input  logic                  clk,
   input  logic                  rst,
   mfcc_mel_filter_acc_if.slave  bus
);

   localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(NUM_BINS - 1);
   localparam logic [FILT_W-1:0] LAST_FILT = FILT_W'(NUM_FILTERS - 1);

   mel_state_e        state_q;
   logic [BIN_W-1:0]  bin_q;
   logic [FILT_W-1:0] filt_q;
   logic              busy_q;
   logic              s1_valid_q, s1_first_q, s1_last_q;
   logic [FILT_W-1:0] s1_filt_q;
   logic [WGT_W-1:0]  s1_wgt_q;
   logic              mac_done;

   // bin_q/filt_q are left untouched on the final address so the RAM/ROM address holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         filt_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q <= RUN;
                  bin_q   <= '0;
                  filt_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               if (bin_q == LAST_BIN) begin
                  if (filt_q == LAST_FILT) begin
                     state_q <= DRAIN;
                  end else begin
                     bin_q  <= '0;
                     filt_q <= filt_q + FILT_W'(1);
                  end
               end else begin
                  bin_q <= bin_q + BIN_W'(1);
               end
            end
            DRAIN: begin
               if (mac_done) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_filt_q  <= '0;
         s1_wgt_q   <= '0;
      end else begin
         s1_valid_q <= (state_q == RUN);
         s1_first_q <= (bin_q == '0);
         s1_last_q  <= (bin_q == LAST_BIN);
         s1_filt_q  <= filt_q;
         s1_wgt_q   <= bus.rom_data;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.spec_addr = bin_q;
   assign bus.rom_addr  = bin_q;
   assign bus.rom_sel   = filt_q;
   assign bus.done      = mac_done;

   mfcc_mel_mac #(
      .NUM_FILTERS (NUM_FILTERS),
      .FILT_W      (FILT_W),
      .SPEC_W      (SPEC_W),
      .WGT_W       (WGT_W),
      .ACC_W       (ACC_W)
   ) u_mac (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (s1_valid_q),
      .first_i      (s1_first_q),
      .last_i       (s1_last_q),
      .filt_i       (s1_filt_q),
      .wgt_i        (s1_wgt_q),
      .spec_i       (bus.spec_rdata),
      .out_valid_o  (bus.out_valid),
      .out_idx_o    (bus.out_idx),
      .out_energy_o (bus.out_energy),
      .done_o       (mac_done)
   );

endmodule

// File: tb/tb_mfcc_mel_filter_acc.sv
// tb/tb_mfcc_mel_filter_acc.sv - directed self-checking bench for mfcc_mel_filter_acc
module tb_mfcc_mel_filter_acc;

   localparam int NB    = 257;
   localparam int NF    = 26;
   localparam int VLAT  = NB + 3;
   localparam int FRAME = 2 + NF * NB + 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mfcc_mel_filter_acc_if bus ();
   mfcc_mel_filter_acc_if #(.ACC_W(40)) aux ();

   mfcc_mel_filter_acc dut (.clk(clk), .rst(rst), .bus(bus));
   mfcc_mel_filter_acc #(.ACC_W(40)) dut_sat (.clk(clk), .rst(rst), .bus(aux));

   logic [31:0] spec_mem [0:511];
   logic [7:0]  wgt_mem  [0:31][0:511];

   always @(posedge clk) bus.spec_rdata <= spec_mem[bus.spec_addr];
   assign bus.rom_data   = wgt_mem[bus.rom_sel][bus.rom_addr];
   assign aux.spec_rdata = 32'hFFFF_FFFF;
   assign aux.rom_data   = 8'hFF;

   int          n_cmp = 0, n_bad = 0;
   logic [4:0]  got_idx [$];
   logic [47:0] got_en  [$];
   int          got_cyc [$];
   int          n_done = 0, done_cyc = 0, rise_cyc = 0, start_cyc = 0, nd0 = 0, n_pre = 0;
   logic [4:0]  done_idx = '0;
   logic        busy_prev = 1'b0;
   logic        aux_seen = 1'b0;
   logic [39:0] aux_en = '0;
   logic [47:0] exp_e [0:25];
   logic [63:0] exp_aux;

   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         got_idx.push_back(bus.out_idx);
         got_en.push_back(bus.out_energy);
         got_cyc.push_back(cyc);
      end
      if (bus.done === 1'b1) begin
         n_done++;
         done_cyc = cyc;
         done_idx = bus.out_idx;
      end
      if (bus.busy === 1'b1 && !busy_prev) rise_cyc = cyc;
      busy_prev = (bus.busy === 1'b1);
      if (aux.out_valid === 1'b1 && !aux_seen) begin
         aux_seen = 1'b1;
         aux_en   = aux.out_energy;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"},       bus.busy,       0);
      check({tag, "_out_valid"},  bus.out_valid,  0);
      check({tag, "_done"},       bus.done,       0);
      check({tag, "_spec_addr"},  bus.spec_addr,  0);
      check({tag, "_rom_addr"},   bus.rom_addr,   0);
      check({tag, "_rom_sel"},    bus.rom_sel,    0);
      check({tag, "_out_idx"},    bus.out_idx,    0);
      check({tag, "_out_energy"}, bus.out_energy, 0);
   endtask

   task automatic start_frame(input logic with_aux);
      got_idx.delete();
      got_en.delete();
      got_cyc.delete();
      nd0 = n_done;
      @(negedge clk);
      bus.start = 1'b1;
      aux.start = with_aux;
      start_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      aux.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < FRAME + 50; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) break;
      end
      check({tag, "_done_seen"}, bus.done, 1);
   endtask

   task automatic check_frame(input string tag);
      int bad = 0;
      check({tag, "_count"}, got_idx.size(), NF);
      for (int i = 0; i < got_idx.size() && i < NF; i++)
         if (got_idx[i] !== 5'(i) || got_en[i] !== exp_e[i]) bad++;
      check({tag, "_content"}, bad, 0);
      check({tag, "_first_lat"}, (got_cyc.size() > 0) ? got_cyc[0] - rise_cyc : -1, VLAT);
      check({tag, "_busy_rise"}, rise_cyc - start_cyc, 1);
      check({tag, "_done_idx"}, done_idx, NF - 1);
      check({tag, "_done_time"}, done_cyc - start_cyc, FRAME);
      check({tag, "_done_count"}, n_done - nd0, 1);
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      aux.start = 1'b0;
      for (int b = 0; b < 512; b++) spec_mem[b] = '0;
      for (int f = 0; f < 32; f++)
         for (int b = 0; b < 512; b++) wgt_mem[f][b] = '0;

      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;

      // Frame A: one narrow band on filter 0, 10 bins x 1000 x 128
      for (int b = 0; b < NB; b++) spec_mem[b] = 32'd1000;
      for (int b = 10; b <= 19; b++) wgt_mem[0][b] = 8'd128;
      for (int f = 0; f < NF; f++) exp_e[f] = '0;
      exp_e[0] = 48'd1_280_000;
      start_frame(1'b0);
      wait_done("A");
      #1;
      check_frame("A");
      check("A_busy_at_done", bus.busy, 1);
      @(negedge clk);
      check("A_busy_after_done", bus.busy, 0);
      check("A_spec_addr_hold", bus.spec_addr, NB - 1);
      check("A_rom_addr_hold", bus.rom_addr, NB - 1);
      check("A_rom_sel_hold", bus.rom_sel, NF - 1);
      check("A_out_valid_low", bus.out_valid, 0);

      // Frame B: all ones x 255, with a stray start mid-frame
      for (int b = 0; b < NB; b++) spec_mem[b] = 32'd1;
      for (int f = 0; f < NF; f++)
         for (int b = 0; b < NB; b++) wgt_mem[f][b] = 8'd255;
      for (int f = 0; f < NF; f++) exp_e[f] = 48'd65_535;
      start_frame(1'b1);
      repeat (1000) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("B");
      #1;
      check_frame("B");
`ifdef MEL_ACC_SAT_EN
      exp_aux = 64'h00FF_FFFF_FFFF;
`else
      exp_aux = 64'h00FE_FFFF_0001;
`endif
      check("SAT_seen", aux_seen, 1);
      check("SAT_energy", aux_en, exp_aux);

      // Frame C: start held across the done cycle and the one after
      got_idx.delete();
      got_en.delete();
      got_cyc.delete();
      nd0 = n_done;
      bus.start = 1'b1;
      @(negedge clk);
      check("C_busy_gap", bus.busy, 0);
      start_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("C");
      #1;
      check_frame("C");

      // Frame D: reset while filter 7 is being scanned
      start_frame(1'b0);
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (bus.rom_sel === 5'd7) break;
      end
      check("D_reach_filter7", bus.rom_sel, 7);
      #1 rst = 1'b1;
      #1;
      check_idle_zero("D_rst");
      n_pre = got_idx.size();
      check("D_pre_reset_count", n_pre, 6);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (400) @(negedge clk);
      check("D_no_valid_after_rst", got_idx.size(), n_pre);
      check("D_no_done_after_rst", n_done - nd0, 0);
      check("D_idle_after_rst", bus.busy, 0);

      // Frame E: one weight per filter, f+1 at bin 9f, spectrum 1000
      for (int b = 0; b < NB; b++) spec_mem[b] = 32'd1000;
      for (int f = 0; f < NF; f++)
         for (int b = 0; b < NB; b++) wgt_mem[f][b] = '0;
      for (int f = 0; f < NF; f++) begin
         wgt_mem[f][9 * f] = 8'(f + 1);
         exp_e[f] = 48'(1000 * (f + 1));
      end
      start_frame(1'b0);
      wait_done("E");
      #1;
      check_frame("E");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
